jedro_1_decoder: RTL and testbench

Instruction decode stage that sits directly downstream of the jedro_1 instruction fetch unit. It consumes the fetched 32-bit RV32I instruction and registers the decoded fields: register addresses, ALU operation, sign-extended immediate and control flags. It drives get_next_instr back to the fetch unit. A small FSM handles start-up, downstream stall, flush on jump, and a sticky trap on an illegal instruction.

---
 rtl/jedro_1_decoder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_jedro_1_decoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_decoder.sv
// jedro_1_decoder: RV32I decode stage behind the jedro_1 fetch unit.
// Decoded fields register one cycle after accept; an illegal opcode traps until reset.
module jedro_1_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic                  instr_valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  get_next_instr_o,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  rf_we_o,
  output logic [3:0]            alu_op_o,
  output logic                  use_imm_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic                  jmp_o,
  output logic                  branch_o,
  output logic                  load_o,
  output logic                  store_o,
  output logic                  pc_rel_o,
  output logic                  illegal_o
);

  // state    | meaning
  // S_IDLE   | first cycle after reset, covers the fetch ROM read delay
  // S_DECODE | accepting and decoding instructions
  // S_TRAP   | illegal instruction accepted, frozen until reset
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_TRAP   = 2'd2
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rf_we;
    logic [3:0]            alu_op;
    logic                  use_imm;
    logic [DATA_WIDTH-1:0] imm;
    logic                  jmp;
    logic                  branch;
    logic                  load;
    logic                  store;
    logic                  pc_rel;
  } fields_t;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  sign;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_b;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] imm_j;

  fields_t dec;
  logic    dec_illegal;

  state_e  state_q, state_d;
  logic    valid_q, valid_d;
  logic    illegal_q, illegal_d;
  fields_t fields_q, fields_d;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign sign   = instr_i[DATA_WIDTH-1];

  assign imm_i = {{(DATA_WIDTH-12){sign}}, instr_i[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){sign}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{(DATA_WIDTH-13){sign}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{(DATA_WIDTH-21){sign}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  // alt selects SUB over ADD and SRA over SRL
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    dec         = '0;
    dec.rs1     = instr_i[19:15];
    dec.rs2     = instr_i[24:20];
    dec.rd      = instr_i[11:7];
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.rf_we  = 1'b1;
        dec.alu_op = alu_from_funct3(funct3, funct7[5]);
        if (funct7 == 7'b0100000) dec_illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
        else                      dec_illegal = (funct7 != 7'b0000000);
      end
      OPC_OP_IMM: begin
        dec.rf_we   = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        dec.alu_op  = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001)      dec_illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101) dec_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_LUI: begin
        dec.rs1     = '0;
        dec.rf_we   = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_u;
      end
      OPC_AUIPC: begin
        dec.pc_rel  = 1'b1;
        dec.rf_we   = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_u;
      end
      OPC_JAL: begin
        dec.jmp     = 1'b1;
        dec.pc_rel  = 1'b1;
        dec.rf_we   = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_j;
      end
      OPC_JALR: begin
        dec.jmp     = 1'b1;
        dec.rf_we   = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        dec_illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.pc_rel = 1'b1;
        dec.imm    = imm_b;
        case (funct3[2:1])
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: dec.alu_op = ALU_SUB;
        endcase
        dec_illegal = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        dec.load    = 1'b1;
        dec.rf_we   = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        dec_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec.store   = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_s;
        dec_illegal = (funct3 > 3'b010);
      end
      OPC_MISC_MEM: ;
      default: dec_illegal = 1'b1;
    endcase
  end

  // flush beats stall beats accept; fields hold whenever nothing new is accepted
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    fields_d  = fields_q;
    case (state_q)
      S_IDLE: state_d = S_DECODE;
      S_DECODE: begin
        if (flush_i) begin
          valid_d = 1'b0;
        end else if (!stall_i) begin
          if (instr_valid_i && dec_illegal) begin
            valid_d   = 1'b0;
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end else if (instr_valid_i) begin
            valid_d  = 1'b1;
            fields_d = dec;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      S_TRAP: begin
        valid_d   = 1'b0;
        illegal_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      fields_q  <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      fields_q  <= fields_d;
    end
  end

  assign get_next_instr_o = (state_q == S_DECODE) && !stall_i && !flush_i;
  assign valid_o          = valid_q;
  assign illegal_o        = illegal_q;
  assign rs1_o            = fields_q.rs1;
  assign rs2_o            = fields_q.rs2;
  assign rd_o             = fields_q.rd;
  assign rf_we_o          = fields_q.rf_we;
  assign alu_op_o         = fields_q.alu_op;
  assign use_imm_o        = fields_q.use_imm;
  assign imm_o            = fields_q.imm;
  assign jmp_o            = fields_q.jmp;
  assign branch_o         = fields_q.branch;
  assign load_o           = fields_q.load;
  assign store_o          = fields_q.store;
  assign pc_rel_o         = fields_q.pc_rel;

endmodule

// File: tb/tb_jedro_1_decoder.sv
// Bench for jedro_1_decoder: directed sequence with literal expectations, then
// randomized traffic compared every cycle against a behavioural decode model.
module tb_jedro_1_decoder;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        stall_i;
  logic        flush_i;
  logic        get_next_instr_o;
  logic        valid_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        rf_we_o;
  logic [3:0]  alu_op_o;
  logic        use_imm_o;
  logic [31:0] imm_o;
  logic        jmp_o, branch_o, load_o, store_o, pc_rel_o, illegal_o;

  int n_checks = 0;
  int n_errors = 0;

  jedro_1_decoder dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .get_next_instr_o(get_next_instr_o),
    .valid_o(valid_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .rf_we_o(rf_we_o),
    .alu_op_o(alu_op_o), .use_imm_o(use_imm_o), .imm_o(imm_o), .jmp_o(jmp_o),
    .branch_o(branch_o), .load_o(load_o), .store_o(store_o), .pc_rel_o(pc_rel_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rf_we;
    logic [3:0]  alu;
    logic        use_imm;
    logic [31:0] imm;
    logic        jmp;
    logic        branch;
    logic        load;
    logic        store;
    logic        pc_rel;
  } fld_t;

  typedef struct packed {
    logic ill;
    fld_t f;
  } dec_t;

  // Reference decode: immediates built arithmetically from a sign mask,
  // ALU codes from a funct3 lookup table plus an "alternate" offset.
  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t        d;
    logic [31:0] sx;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [3:0]  alu_base [8];
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    alu_base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    sx = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    i_imm = (sx << 11) | 32'(ins[30:20]);
    s_imm = (sx << 11) | (32'(ins[30:25]) << 5) | 32'(ins[11:7]);
    b_imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    u_imm = ins & 32'hFFFF_F000;
    j_imm = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    d = '0;
    d.f.rs1 = ins[19:15];
    d.f.rs2 = ins[24:20];
    d.f.rd  = ins[11:7];
    if (ins[1:0] != 2'b11) begin
      d.ill = 1'b1;
    end else begin
      case (ins[6:2])
        5'b01100: begin
          d.f.rf_we = 1'b1;
          d.f.alu   = alu_base[f3] + ((f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ? 4'd1 : 4'd0);
          d.ill     = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        end
        5'b00100: begin
          d.f.rf_we = 1'b1; d.f.use_imm = 1'b1; d.f.imm = i_imm;
          d.f.alu   = alu_base[f3] + ((f3 == 3'd5 && f7 == 7'h20) ? 4'd1 : 4'd0);
          d.ill     = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
        end
        5'b01101: begin
          d.f.rs1 = 5'd0; d.f.rf_we = 1'b1; d.f.use_imm = 1'b1; d.f.imm = u_imm;
        end
        5'b00101: begin
          d.f.pc_rel = 1'b1; d.f.rf_we = 1'b1; d.f.use_imm = 1'b1; d.f.imm = u_imm;
        end
        5'b11011: begin
          d.f.jmp = 1'b1; d.f.pc_rel = 1'b1; d.f.rf_we = 1'b1; d.f.use_imm = 1'b1; d.f.imm = j_imm;
        end
        5'b11001: begin
          d.f.jmp = 1'b1; d.f.rf_we = 1'b1; d.f.use_imm = 1'b1; d.f.imm = i_imm;
          d.ill   = (f3 != 3'd0);
        end
        5'b11000: begin
          d.f.branch = 1'b1; d.f.pc_rel = 1'b1; d.f.imm = b_imm;
          d.f.alu    = (f3 >= 3'd6) ? 4'd4 : ((f3 >= 3'd4) ? 4'd3 : 4'd1);
          d.ill      = (f3 == 3'd2 || f3 == 3'd3);
        end
        5'b00000: begin
          d.f.load = 1'b1; d.f.rf_we = 1'b1; d.f.use_imm = 1'b1; d.f.imm = i_imm;
          d.ill    = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        end
        5'b01000: begin
          d.f.store = 1'b1; d.f.use_imm = 1'b1; d.f.imm = s_imm;
          d.ill     = (f3 > 3'd2);
        end
        5'b00011: ;
        default: d.ill = 1'b1;
      endcase
    end
    return d;
  endfunction

  // Behavioural model: phase 0 = first cycle out of reset, 1 = running, 2 = trapped.
  int   m_phase = 0;
  logic m_valid = 1'b0;
  logic m_ill   = 1'b0;
  logic m_known = 1'b1;
  fld_t m_f     = '0;
  dec_t m_dec;

  assign m_dec = ref_decode(instr_i);

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_phase <= 0; m_valid <= 1'b0; m_ill <= 1'b0; m_known <= 1'b1; m_f <= '0;
    end else if (m_phase == 0) begin
      m_phase <= 1;
    end else if (m_phase == 1) begin
      if (flush_i) begin
        m_valid <= 1'b0; m_known <= 1'b0;
      end else if (!stall_i) begin
        if (instr_valid_i && m_dec.ill) begin
          m_valid <= 1'b0; m_ill <= 1'b1; m_phase <= 2; m_known <= 1'b0;
        end else if (instr_valid_i) begin
          m_valid <= 1'b1; m_f <= m_dec.f; m_known <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_fields();
    return 64'({rs1_o, rs2_o, rd_o, rf_we_o, alu_op_o, use_imm_o, imm_o,
                jmp_o, branch_o, load_o, store_o, pc_rel_o});
  endfunction

  always @(negedge clk_i) begin
    chk("get_next", 64'(get_next_instr_o), 64'((m_phase == 1) && !stall_i && !flush_i));
    chk("valid", 64'(valid_o), 64'(m_valid));
    chk("illegal", 64'(illegal_o), 64'(m_ill));
    if (m_known) chk("fields", dut_fields(), 64'(m_f));
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  ops [10];
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0F};
    w = $urandom;
    if ($urandom_range(99) < 5) return w;
    w[6:0] = ops[$urandom_range(9)];
    case ($urandom_range(9))
      0, 1, 2, 3, 4: w[31:25] = 7'h00;
      5, 6, 7:       w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  dec_t tmp;
  int   trap_cycles;

  initial begin
    rstn_i = 1'b0; instr_valid_i = 1'b1; instr_i = 32'h0050_0093; stall_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rstn_i = 1'b1;
    @(negedge clk_i);
    chk("lit_idle_get_next", 64'(get_next_instr_o), 64'd0);
    chk("lit_reset_imm", 64'(imm_o), 64'd0);

    tick();
    @(negedge clk_i);
    chk("lit_decode_get_next", 64'(get_next_instr_o), 64'd1);

    tick(); instr_i = 32'h4020_81B3;
    @(negedge clk_i);
    chk("lit_addi_valid", 64'(valid_o), 64'd1);
    chk("lit_addi_rd", 64'(rd_o), 64'd1);
    chk("lit_addi_rs1", 64'(rs1_o), 64'd0);
    chk("lit_addi_imm", 64'(imm_o), 64'd5);
    chk("lit_addi_alu", 64'(alu_op_o), 64'd0);
    chk("lit_addi_ctl", 64'({use_imm_o, rf_we_o}), 64'b11);

    tick(); instr_i = 32'hFE20_AE23;
    @(negedge clk_i);
    chk("lit_sub_regs", 64'({rd_o, rs1_o, rs2_o}), 64'({5'd3, 5'd1, 5'd2}));
    chk("lit_sub_alu", 64'(alu_op_o), 64'd1);
    chk("lit_sub_ctl", 64'({use_imm_o, rf_we_o}), 64'b01);

    tick(); instr_i = 32'h0080_00EF;
    @(negedge clk_i);
    chk("lit_sw_store", 64'(store_o), 64'd1);
    chk("lit_sw_imm", 64'(imm_o), 64'hFFFF_FFFC);
    chk("lit_sw_rf_we", 64'(rf_we_o), 64'd0);

    tick(); stall_i = 1'b1; instr_i = 32'h0000_0013;
    @(negedge clk_i);
    chk("lit_jal_flags", 64'({jmp_o, pc_rel_o}), 64'b11);
    chk("lit_jal_rd", 64'(rd_o), 64'd1);
    chk("lit_jal_imm", 64'(imm_o), 64'd8);
    for (int i = 0; i < 2; i++) begin
      tick(); instr_i = $urandom;
      @(negedge clk_i);
      chk("lit_stall_imm", 64'(imm_o), 64'd8);
      chk("lit_stall_get_next", 64'(get_next_instr_o), 64'd0);
    end
    tick(); stall_i = 1'b0; instr_i = 32'h00A0_0293;
    @(negedge clk_i);
    chk("lit_stall_last_hold", 64'({valid_o, jmp_o}), 64'b11);
    tick();
    @(negedge clk_i);
    chk("lit_after_stall_rd", 64'(rd_o), 64'd5);
    chk("lit_after_stall_imm", 64'(imm_o), 64'd10);

    tick(); flush_i = 1'b1; instr_i = 32'h0010_0113;
    @(negedge clk_i);
    chk("lit_flush_get_next", 64'(get_next_instr_o), 64'd0);
    tick(); flush_i = 1'b0;
    @(negedge clk_i);
    chk("lit_flush_valid", 64'(valid_o), 64'd0);
    tick(); instr_i = 32'h0000_0000;
    @(negedge clk_i);
    chk("lit_post_flush", 64'({valid_o, rd_o}), 64'({1'b1, 5'd2}));

    tick();
    @(negedge clk_i);
    chk("lit_trap", 64'({illegal_o, valid_o}), 64'b10);
    for (int i = 0; i < 12; i++) begin
      tick(); flush_i = (i % 2) == 0;
      @(negedge clk_i);
      chk("lit_trap_get_next", 64'(get_next_instr_o), 64'd0);
      chk("lit_trap_sticky", 64'(illegal_o), 64'd1);
    end
    tick(); flush_i = 1'b0;
    #1 rstn_i = 1'b0;
    #1 chk("lit_async_clear", 64'({illegal_o, valid_o}), 64'd0);
    tick(); tick(); rstn_i = 1'b1;

    trap_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (m_phase == 2) trap_cycles++;
      if (trap_cycles > 6) begin
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        trap_cycles = 0;
      end
      stall_i       = $urandom_range(99) < 15;
      flush_i       = $urandom_range(99) < 8;
      instr_valid_i = $urandom_range(99) < 85;
      instr_i = gen_instr();
      tmp = ref_decode(instr_i);
      for (int t = 0; t < 4 && tmp.ill && $urandom_range(99) < 80; t++) begin
        instr_i = gen_instr();
        tmp = ref_decode(instr_i);
      end
    end
    tick();
    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
